// File: rtl/faddsub_sched.sv
// faddsub_sched: round-robin scheduler sharing one pipelined FP32 add/sub unit
// between NUM_REQ requesters.
//
// Ports:
//   i_CLK, i_NRST        clock, asynchronous active-low reset
//   i_REQ_VALID/OP_A/OP_B/SUB, o_REQ_READY
//                        per-requester request handshake (operands packed 32 bits each)
//   o_FU_VALID/OP_A/OP_B/ADD_or_SUB
//                        registered issue port to the unit
//   i_FU_RESULT/FLAGS    unit result, FU_LAT cycles after o_FU_VALID
//   o_RESP_VALID/RESULT/FLAGS, i_RESP_READY
//                        per-requester response buffers and handshake
module faddsub_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned FU_LAT  = 3
) (
    input  logic                  i_CLK,
    input  logic                  i_NRST,
    input  logic [NUM_REQ-1:0]    i_REQ_VALID,
    input  logic [NUM_REQ*32-1:0] i_REQ_OP_A,
    input  logic [NUM_REQ*32-1:0] i_REQ_OP_B,
    input  logic [NUM_REQ-1:0]    i_REQ_SUB,
    output logic [NUM_REQ-1:0]    o_REQ_READY,
    output logic                  o_FU_VALID,
    output logic [31:0]           o_FU_OP_A,
    output logic [31:0]           o_FU_OP_B,
    output logic                  o_FU_ADD_or_SUB,
    input  logic [31:0]           i_FU_RESULT,
    input  logic [4:0]            i_FU_FLAGS,
    output logic [NUM_REQ-1:0]    o_RESP_VALID,
    output logic [NUM_REQ*32-1:0] o_RESP_RESULT,
    output logic [NUM_REQ*5-1:0]  o_RESP_FLAGS,
    input  logic [NUM_REQ-1:0]    i_RESP_READY
);

    localparam int unsigned TAG_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                  issue_valid_q, issue_valid_d;
    logic [31:0]           issue_a_q, issue_a_d;
    logic [31:0]           issue_b_q, issue_b_d;
    logic                  issue_sub_q, issue_sub_d;
    logic [TAG_W-1:0]      issue_tag_q, issue_tag_d;

    logic [FU_LAT-1:0]     pipe_vld_q;
    logic [TAG_W-1:0]      pipe_tag_q [FU_LAT];

    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [NUM_REQ*32-1:0] resp_result_q, resp_result_d;
    logic [NUM_REQ*5-1:0]  resp_flags_q, resp_flags_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [TAG_W-1:0]      grant_tag;
    logic                  found;
    logic                  accept;
    logic [NUM_REQ-1:0]    handshake;
    logic [TAG_W-1:0]      out_tag;
    int unsigned           idx;

    assign eligible = i_REQ_VALID & ~busy_q;

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_tag = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_tag  = TAG_W'(idx);
            end
        end
    end

    // Grant is masked while reset is held so every output reads zero.
    assign o_REQ_READY = grant & {NUM_REQ{i_NRST}};
    assign accept      = found & i_NRST;
    assign handshake   = resp_valid_q & i_RESP_READY;
    assign out_tag     = pipe_tag_q[FU_LAT-1];

    always_comb begin
        busy_d        = (busy_q | o_REQ_READY) & ~handshake;
        rr_ptr_d      = rr_ptr_q;
        issue_valid_d = accept;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_sub_d   = issue_sub_q;
        issue_tag_d   = issue_tag_q;
        if (accept) begin
            rr_ptr_d    = TAG_W'((32'(grant_tag) + 1) % NUM_REQ);
            issue_a_d   = i_REQ_OP_A[32*grant_tag +: 32];
            issue_b_d   = i_REQ_OP_B[32*grant_tag +: 32];
            issue_sub_d = i_REQ_SUB[grant_tag];
            issue_tag_d = grant_tag;
        end
    end

    // The busy credit guarantees the target buffer is empty when a result lands.
    always_comb begin
        resp_valid_d  = resp_valid_q & ~handshake;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        if (pipe_vld_q[FU_LAT-1]) begin
            resp_valid_d[out_tag]            = 1'b1;
            resp_result_d[32*out_tag +: 32]  = i_FU_RESULT;
            resp_flags_d[5*out_tag +: 5]     = i_FU_FLAGS;
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRST) begin
        if (!i_NRST) begin
            busy_q        <= '0;
            rr_ptr_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_sub_q   <= 1'b0;
            issue_tag_q   <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_sub_q   <= issue_sub_d;
            issue_tag_q   <= issue_tag_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
        end
    end

    // Tag pipe tracks which requester owns the unit output each cycle.
    always_ff @(posedge i_CLK or negedge i_NRST) begin
        if (!i_NRST) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < int'(FU_LAT); k++) begin
                pipe_tag_q[k] <= '0;
            end
        end else begin
            for (int k = int'(FU_LAT) - 1; k > 0; k--) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
            pipe_vld_q[0] <= issue_valid_q;
            pipe_tag_q[0] <= issue_tag_q;
        end
    end

    assign o_FU_VALID      = issue_valid_q;
    assign o_FU_OP_A       = issue_a_q;
    assign o_FU_OP_B       = issue_b_q;
    assign o_FU_ADD_or_SUB = issue_sub_q;
    assign o_RESP_VALID    = resp_valid_q;
    assign o_RESP_RESULT   = resp_result_q;
    assign o_RESP_FLAGS    = resp_flags_q;

endmodule
